// File: rtl/interrupt_priority_controller.sv
// rtl/interrupt_priority_controller.sv - 68000 interrupt priority encoder and IACK responder
// Define VECTORED_INT_EN for vectored acknowledge; the default build answers with autovector.
module interrupt_priority_controller #(
  parameter int         NUM_SOURCES = 7,
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic                   CPUCLK_IN,
  input  logic                   RUN_IN,
  input  logic [NUM_SOURCES-1:0] INT_REQ_IN,
  input  logic                   AS_IN,
  input  logic                   UDS_IN,
  input  logic                   LDS_IN,
  input  logic [2:0]             MPU_STATUS_CODE_IN,
  input  logic [2:0]             ACK_LEVEL_IN,
  input  logic                   REG_WR_IN,
  input  logic [1:0]             REG_SEL_IN,
  input  logic [7:0]             REG_WDATA_IN,
  output logic [7:0]             REG_RDATA,
  output logic [2:0]             INT_LEVEL,
  output logic                   INT_AUTOVEC_REQ,
  output logic                   INT_VECTOR_REQ,
  output logic [7:0]             INT_VECTOR
);

  localparam int N = NUM_SOURCES;

  typedef enum logic [1:0] {IDLE, GRANT, SPUR} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sd_q, sd_d;
  logic [N-1:0] enable_q, enable_d, edge_q, edge_d, pending_q, pending_d;
  logic         spurious_q, spurious_d;
  logic [2:0]   int_level_q, int_level_d;
  logic [2:0]   ack_level_q, ack_level_d;

  logic [N-1:0] active, rise, clr, ack_onehot;
  logic         ackcyc, grant_ok, grant_entry, spur_entry;
  logic [2:0]   top_lvl;

  always_comb begin
    sync1_d     = INT_REQ_IN;
    sync2_d     = sync1_q;
    sd_d        = sync2_q;
    state_d     = state_q;
    ack_level_d = ack_level_q;
    enable_d    = enable_q;
    edge_d      = edge_q;
    spurious_d  = spurious_q;
    grant_entry = 1'b0;
    spur_entry  = 1'b0;
    grant_ok    = 1'b0;
    ack_onehot  = '0;
    top_lvl     = 3'd0;

    ackcyc = AS_IN & UDS_IN & LDS_IN & (MPU_STATUS_CODE_IN == 3'b111);
    active = pending_q & enable_q;
    rise   = sync2_q & ~sd_q;

    // Levels 0 and above NUM_SOURCES never match, so they fall through to SPUR.
    for (int i = 0; i < N; i++) begin
      if (ACK_LEVEL_IN == 3'(i + 1)) begin
        ack_onehot[i] = 1'b1;
        grant_ok      = active[i];
      end
      if (active[i]) top_lvl = 3'(i + 1);
    end

    case (state_q)
      IDLE: begin
        if (ackcyc) begin
          if (grant_ok) begin
            state_d     = GRANT;
            ack_level_d = ACK_LEVEL_IN;
            grant_entry = 1'b1;
          end else begin
            state_d    = SPUR;
            spur_entry = 1'b1;
          end
        end
      end
      GRANT, SPUR: begin
        if (!AS_IN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (REG_WR_IN && REG_SEL_IN == 2'd0) enable_d = REG_WDATA_IN[N-1:0];
    if (REG_WR_IN && REG_SEL_IN == 2'd1) edge_d   = REG_WDATA_IN[N-1:0];

    clr = (grant_entry ? ack_onehot : '0)
        | ((REG_WR_IN && REG_SEL_IN == 2'd2) ? REG_WDATA_IN[N-1:0] : '0);

    // Edge bits hold until cleared (a new rise beats a clear); level bits follow S.
    pending_d = (edge_q & ((pending_q & ~clr) | rise)) | (~edge_q & sync2_q);

    if (REG_WR_IN && REG_SEL_IN == 2'd3 && REG_WDATA_IN[7]) spurious_d = 1'b0;
    if (spur_entry) spurious_d = 1'b1;

    int_level_d = top_lvl;
  end

  always_ff @(negedge CPUCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sd_q        <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      pending_q   <= '0;
      spurious_q  <= 1'b0;
      int_level_q <= 3'd0;
      ack_level_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sd_q        <= sd_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      pending_q   <= pending_d;
      spurious_q  <= spurious_d;
      int_level_q <= int_level_d;
      ack_level_q <= ack_level_d;
    end
  end

  always_comb begin
    REG_RDATA = 8'h00;
    case (REG_SEL_IN)
      2'd0: REG_RDATA = 8'(enable_q);
      2'd1: REG_RDATA = 8'(edge_q);
      2'd2: REG_RDATA = 8'(pending_q);
      2'd3: REG_RDATA = {spurious_q, 1'b0, state_q == GRANT, 2'b00, int_level_q};
      default: REG_RDATA = 8'h00;
    endcase
  end

  assign INT_LEVEL = int_level_q;

`ifdef VECTORED_INT_EN
  assign INT_AUTOVEC_REQ = 1'b0;
  assign INT_VECTOR_REQ  = (state_q == GRANT);
  assign INT_VECTOR      = (state_q == GRANT) ? VECTOR_BASE + {5'b00000, ack_level_q} : 8'h00;
`else
  logic unused_vec;
  assign unused_vec      = ^{VECTOR_BASE, ack_level_q};
  assign INT_AUTOVEC_REQ = (state_q == GRANT);
  assign INT_VECTOR_REQ  = 1'b0;
  assign INT_VECTOR      = 8'h00;
`endif

endmodule

// File: tb/tb_interrupt_priority_controller.sv
// tb/tb_interrupt_priority_controller.sv - randomized bench with behavioural interrupt model
module tb_interrupt_priority_controller;
  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         as_i = 1'b0, uds = 1'b0, lds = 1'b0;
  logic [2:0]   fc = 3'd0, ack_lvl = 3'd0;
  logic         reg_wr = 1'b0;
  logic [1:0]   reg_sel = 2'd0;
  logic [7:0]   wdata = 8'h00;
  logic [7:0]   rdata;
  logic [2:0]   int_level;
  logic         autovec, vec_req;
  logic [7:0]   vector;

  interrupt_priority_controller dut (
    .CPUCLK_IN(clk), .RUN_IN(rst_n), .INT_REQ_IN(req),
    .AS_IN(as_i), .UDS_IN(uds), .LDS_IN(lds), .MPU_STATUS_CODE_IN(fc),
    .ACK_LEVEL_IN(ack_lvl), .REG_WR_IN(reg_wr), .REG_SEL_IN(reg_sel),
    .REG_WDATA_IN(wdata), .REG_RDATA(rdata), .INT_LEVEL(int_level),
    .INT_AUTOVEC_REQ(autovec), .INT_VECTOR_REQ(vec_req), .INT_VECTOR(vector)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw request history stands in for the synchroniser delay.
  bit [N-1:0] m_hist [3];
  bit [N-1:0] m_en, m_edge, m_pend;
  bit         m_spur, m_granted, m_spur_busy;
  int         m_lvl, m_ack_l;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_en = '0; m_edge = '0; m_pend = '0;
    m_spur = 0; m_granted = 0; m_spur_busy = 0;
    m_lvl = 0; m_ack_l = 0;
  endtask

  function automatic int highest(input bit [N-1:0] a);
    int r = 0;
    for (int i = 0; i < N; i++) if (a[i]) r = i + 1;
    return r;
  endfunction

  task automatic model_step();
    bit [N-1:0] s, sd, act, clr, np;
    bit ackcyc, busy, g, sp;
    int L;
    s = m_hist[1];
    sd = m_hist[2];
    act = m_pend & m_en;
    ackcyc = as_i && uds && lds && (fc == 3'd7);
    busy = m_granted || m_spur_busy;
    L = int'(ack_lvl);
    g = !busy && ackcyc && L >= 1 && L <= N && act[L-1];
    sp = !busy && ackcyc && !g;
    clr = '0;
    if (g) clr[L-1] = 1'b1;
    if (reg_wr && reg_sel == 2'd2) clr |= wdata[N-1:0];
    for (int i = 0; i < N; i++)
      np[i] = m_edge[i] ? ((m_pend[i] && !clr[i]) || (s[i] && !sd[i])) : s[i];
    m_lvl = highest(act);
    if (reg_wr) begin
      case (reg_sel)
        2'd0: m_en = wdata[N-1:0];
        2'd1: m_edge = wdata[N-1:0];
        2'd3: if (wdata[7]) m_spur = 0;
        default: ;
      endcase
    end
    if (sp) m_spur = 1;
    if (busy && !as_i) begin
      m_granted = 0;
      m_spur_busy = 0;
    end
    if (g) begin
      m_granted = 1;
      m_ack_l = L;
    end
    if (sp) m_spur_busy = 1;
    m_pend = np;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = req;
  endtask

  function automatic logic [7:0] exp_rdata(input logic [1:0] sel);
    case (sel)
      2'd0: return {1'b0, m_en};
      2'd1: return {1'b0, m_edge};
      2'd2: return {1'b0, m_pend};
      default: return {m_spur, 1'b0, m_granted, 2'b00, 3'(m_lvl)};
    endcase
  endfunction

  task automatic compare_all();
    check_eq("int_level", int_level, m_lvl);
`ifdef VECTORED_INT_EN
    check_eq("autovec", autovec, 0);
    check_eq("vec_req", vec_req, m_granted);
    check_eq("vector", vector, m_granted ? 8'(8'h40 + m_ack_l) : 8'h00);
`else
    check_eq("autovec", autovec, m_granted);
    check_eq("vec_req", vec_req, 0);
    check_eq("vector", vector, 0);
`endif
    check_eq("rdata", rdata, exp_rdata(reg_sel));
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [7:0] data);
    reg_wr = 1'b1; reg_sel = sel; wdata = data;
    tick();
    reg_wr = 1'b0; wdata = 8'h00;
  endtask

  task automatic ack_start(input logic [2:0] lvl);
    as_i = 1'b1; uds = 1'b1; lds = 1'b1; fc = 3'd7; ack_lvl = lvl;
  endtask

  task automatic ack_end();
    as_i = 1'b0; uds = 1'b0; lds = 1'b0; fc = 3'd0; ack_lvl = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_hold;
    int k;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_level", int_level, 0);
    check_eq("rst_ack", {autovec, vec_req}, 0);
    check_eq("rst_vector", vector, 0);
    check_eq("rst_enable", rdata, 0);
    rst_n = 1'b1;

    // edge source 0: four-cycle latency, ack clears it
    write_reg(2'd1, 8'h01);
    write_reg(2'd0, 8'h07);
    reg_sel = 2'd2;
    req = 7'h01; tick(); req = '0;
    tick(); tick();
    check_eq("t1_pend", rdata, 8'h01);
    check_eq("t1_lvl_early", int_level, 0);
    tick();
    check_eq("t1_lvl", int_level, 1);
    ack_start(3'd1); tick();
    check_eq("t1_ack", autovec | vec_req, 1);
    tick();
    check_eq("t1_ack_hold", autovec | vec_req, 1);
    check_eq("t1_pend_clr", rdata, 8'h00);
    check_eq("t1_lvl_clr", int_level, 0);
    ack_end(); tick();
    check_eq("t1_ack_drop", autovec | vec_req, 0);

    // level sources 1 and 2, enable change
    write_reg(2'd1, 8'h00);
    req = 7'h06;
    write_reg(2'd0, 8'h06);
    repeat (5) tick();
    check_eq("t2_lvl3", int_level, 3);
    write_reg(2'd0, 8'h02);
    tick();
    check_eq("t2_lvl2", int_level, 2);
    reg_sel = 2'd2; tick();
    check_eq("t2_pend", rdata, 8'h06);

    // spurious acknowledge
    req = '0;
    write_reg(2'd0, 8'h00);
    repeat (4) tick();
    check_eq("t3_lvl0", int_level, 0);
    reg_sel = 2'd3;
    ack_start(3'd5); tick();
    check_eq("t3_noack", {autovec, vec_req}, 0);
    check_eq("t3_spur", rdata[7], 1);
    tick(); ack_end(); tick();
    write_reg(2'd3, 8'h80);
    check_eq("t3_spur_clr", rdata[7], 0);

    // new rising edge coincides with the acknowledge that clears it
    write_reg(2'd1, 8'h01);
    write_reg(2'd0, 8'h01);
    req = 7'h01; tick(); req = '0;
    repeat (4) tick();
    check_eq("t4_lvl", int_level, 1);
    req = 7'h01; tick(); tick();
    ack_start(3'd1); reg_sel = 2'd2; tick();
    check_eq("t4_pend", rdata, 8'h01);
    req = '0; tick(); ack_end(); tick(); tick();
    check_eq("t4_lvl_after", int_level, 1);

    // acknowledge of level 3, latched level survives ACK_LEVEL_IN change
    write_reg(2'd1, 8'h00);
    req = 7'h04;
    write_reg(2'd0, 8'h04);
    repeat (5) tick();
    check_eq("t5_lvl", int_level, 3);
    ack_start(3'd3); tick();
`ifdef VECTORED_INT_EN
    check_eq("t5_vreq", vec_req, 1);
    check_eq("t5_vec", vector, 8'h43);
    check_eq("t5_avec", autovec, 0);
`else
    check_eq("t5_avec", autovec, 1);
    check_eq("t5_vreq", vec_req, 0);
    check_eq("t5_vec", vector, 0);
`endif
    ack_lvl = 3'd6; tick();

    // reset during GRANT
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_lvl", int_level, 0);
    check_eq("t6_ack", {autovec, vec_req}, 0);
    check_eq("t6_vec", vector, 0);
    model_reset();
    ack_end(); req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reg_sel = 2'd0;
    tick();
    check_eq("t6_enable", rdata, 8'h00);

    // randomized traffic
    ack_hold = 0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N - 1);
        req[k] = ~req[k];
      end
      reg_wr = 1'b0;
      reg_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 2) begin
        reg_wr = 1'b1;
        wdata = 8'($urandom);
      end
      if (ack_hold > 0) begin
        ack_hold--;
        if (ack_hold == 0) ack_end();
        else if ($urandom_range(0, 2) == 0) ack_lvl = 3'($urandom_range(0, 7));
      end else if (!as_i && $urandom_range(0, 5) == 0) begin
        as_i = 1'b1;
        uds = ($urandom_range(0, 4) != 0);
        lds = 1'b1;
        fc = ($urandom_range(0, 4) != 0) ? 3'd7 : 3'($urandom_range(0, 7));
        ack_lvl = 3'($urandom_range(0, 7));
        ack_hold = $urandom_range(1, 4);
      end
      tick();
    end
    reg_wr = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
